// File: rtl/ad5791_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ad5791_stream_monitor
// Purpose  : Deserializes the SYNC-framed AD5791 serial link from the
//            pin readback into NUM_DAC parallel words.
// Revision : 1.0 - initial release
// ============================================================================
module ad5791_stream_monitor #(
    parameter int NUM_DAC     = 4,
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          a_clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [7:0]                    RP_exp_in,
    output logic [NUM_DAC*FRAME_BITS-1:0] dac_word,
    output logic                          dac_valid,
    output logic                          frame_error,
    output logic [5:0]                    bit_count,
    output logic [31:0]                   frame_count
);

    localparam int         c_W        = NUM_DAC * FRAME_BITS;
    // Idle pin levels: serial clock (bit 0) and sync (bit 3) high.
    localparam logic [5:0] c_PIN_IDLE = 6'b001001;
    // Pin index carrying each lane's data, lane 0 in the low field.
    localparam logic [23:0] c_LANE_PIN = {6'd5, 6'd4, 6'd2, 6'd1};
    localparam logic [5:0] c_CNT_MAX  = 6'd63;
    localparam logic [5:0] c_FRAME_LEN = 6'(FRAME_BITS);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [5:0]         r_sync [SYNC_STAGES];
    logic [5:0]         r_hist;
    logic [5:0]         w_cur;
    logic [NUM_DAC-1:0] w_lane_bit;
    logic               w_unused_pins;

    logic               r_fall_clk;
    logic               r_fall_sync;
    logic               r_rise_sync;
    logic [NUM_DAC-1:0] r_data;

    logic [0:0]         r_state, w_state;
    logic [5:0]         r_cnt, w_cnt;
    logic [c_W-1:0]     r_shift, w_shift;
    logic [c_W-1:0]     w_word;
    logic               w_valid, w_err;
    logic [5:0]         w_bit_count;
    logic [31:0]        w_frame_count;

    assign w_cur         = r_sync[SYNC_STAGES-1];
    assign w_unused_pins = ^{RP_exp_in[7:6], w_cur};

    for (genvar k = 0; k < NUM_DAC; k++) begin : g_lane
        assign w_lane_bit[k] = w_cur[c_LANE_PIN[k*6 +: 6]];
    end

    // Synchronizer, history flop and registered edge strobes; the data
    // bits are registered alongside so they stay aligned with the strobes.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= c_PIN_IDLE;
            r_hist      <= c_PIN_IDLE;
            r_fall_clk  <= 1'b0;
            r_fall_sync <= 1'b0;
            r_rise_sync <= 1'b0;
            r_data      <= '0;
        end else begin
            r_sync[0] <= RP_exp_in[5:0];
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_hist      <= w_cur;
            r_fall_clk  <= r_hist[0] & ~w_cur[0];
            r_fall_sync <= r_hist[3] & ~w_cur[3];
            r_rise_sync <= ~r_hist[3] & w_cur[3];
            r_data      <= w_lane_bit;
        end
    end

    always_ff @(posedge a_clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            dac_word    <= '0;
            dac_valid   <= 1'b0;
            frame_error <= 1'b0;
            bit_count   <= '0;
            frame_count <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_shift     <= w_shift;
            dac_word    <= w_word;
            dac_valid   <= w_valid;
            frame_error <= w_err;
            bit_count   <= w_bit_count;
            frame_count <= w_frame_count;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_shift       = r_shift;
        w_word        = dac_word;
        w_valid       = 1'b0;
        w_err         = 1'b0;
        w_bit_count   = bit_count;
        w_frame_count = frame_count;
        case (r_state)
            S_IDLE: begin
                if (enable && r_fall_sync) begin
                    w_state = S_SHIFT;
                    w_cnt   = '0;
                    w_shift = '0;
                end
            end
            S_SHIFT: begin
                if (!enable) begin
                    w_state = S_IDLE;
                end else begin
                    // Shift first so a coincident close sees the new bit.
                    if (r_fall_clk) begin
                        for (int k = 0; k < NUM_DAC; k++)
                            w_shift[k*FRAME_BITS +: FRAME_BITS] =
                                {r_shift[k*FRAME_BITS +: FRAME_BITS-1], r_data[k]};
                        if (r_cnt != c_CNT_MAX) w_cnt = r_cnt + 6'd1;
                    end
                    if (r_rise_sync) begin
                        if (w_cnt == c_FRAME_LEN) begin
                            w_word        = w_shift;
                            w_valid       = 1'b1;
                            w_frame_count = frame_count + 32'd1;
                        end else begin
                            w_err = 1'b1;
                        end
                        w_bit_count = w_cnt;
                        w_state     = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
